if_fetch_unit: RTL and testbench

//  Instruction-fetch front end: the PC register and fetch sequencer that consumes the next-PC

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Address phase is req/gnt; data phase is a single rvalid pulse per granted request.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding fetch sequencer and a
// two-entry instruction queue toward ID, with redirect flush and wrong-path kill.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    input  logic            stall,
    if_fetch_unit_if.master imem,
    output logic            if_valid,
    output logic [31:0]     if_pc,
    output logic [31:0]     if_pc4,
    output logic [31:0]     if_inst
);
    localparam logic [1:0] QFULL = 2'(QDEPTH);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] req_addr_r;
    logic [31:0] req_addr_s;
    logic        kill_r;
    logic        kill_s;
    logic        req_r;
    logic        req_s;
    logic [1:0]  count_r;
    logic [1:0]  count_s;
    logic        valid_r;
    logic [31:0] head_pc_r;
    logic [31:0] head_inst_r;
    logic [31:0] head_pc4_r;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_inst_r;
    logic [31:0] head_pc_s;
    logic [31:0] head_inst_s;
    logic [31:0] tail_pc_s;
    logic [31:0] tail_inst_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] redir_pc_s;
    logic        unused_low_s;

    assign redir_pc_s   = {redirect_pc[31:2], 2'b00};
    assign unused_low_s = ^redirect_pc[1:0];

    // Queue occupancy: a redirect flushes and suppresses both push and pop.
    always_comb begin
        pop_s   = 1'b0;
        push_s  = 1'b0;
        count_s = count_r;
        pop_s   = valid_r && !stall && !redirect_valid;
        push_s  = (state_r == S_WAIT) && imem.rvalid && !kill_r && !redirect_valid;
        if (redirect_valid) begin
            count_s = 2'd0;
        end else if (push_s && !pop_s) begin
            count_s = count_r + 2'd1;
        end else if (!push_s && pop_s) begin
            count_s = count_r - 2'd1;
        end else begin
            count_s = count_r;
        end
    end

    // Queue storage: head shifts from tail on pop, the new word lands in the first free slot.
    always_comb begin
        head_pc_s   = head_pc_r;
        head_inst_s = head_inst_r;
        tail_pc_s   = tail_pc_r;
        tail_inst_s = tail_inst_r;
        if (pop_s) begin
            head_pc_s   = tail_pc_r;
            head_inst_s = tail_inst_r;
        end else begin
            head_pc_s   = head_pc_r;
            head_inst_s = head_inst_r;
        end
        if (push_s) begin
            if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
                head_pc_s   = req_addr_r;
                head_inst_s = imem.rdata;
            end else begin
                tail_pc_s   = req_addr_r;
                tail_inst_s = imem.rdata;
            end
        end else begin
            tail_pc_s   = tail_pc_r;
            tail_inst_s = tail_inst_r;
        end
    end

    // Fetch sequencer: next state, next PC and wrong-path kill tracking.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        kill_s     = kill_r;
        req_addr_s = req_addr_r;
        req_s      = 1'b0;
        case (state_r)
            S_BOOT: begin
                state_s = S_REQ;
                pc_s    = redirect_valid ? redir_pc_s : pc_r;
            end
            S_REQ: begin
                if (imem.gnt) begin
                    state_s = S_WAIT;
                    if (redirect_valid) begin
                        pc_s   = redir_pc_s;
                        kill_s = 1'b1;
                    end else if (kill_r) begin
                        // granted request is already wrong-path; pc holds the redirect target
                        pc_s = pc_r;
                    end else begin
                        pc_s = pc_r + 32'd4;
                    end
                end else begin
                    state_s = S_REQ;
                    if (redirect_valid) begin
                        pc_s   = redir_pc_s;
                        kill_s = 1'b1;
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end
            S_WAIT: begin
                pc_s = redirect_valid ? redir_pc_s : pc_r;
                if (imem.rvalid) begin
                    kill_s  = 1'b0;
                    state_s = (count_s < QFULL) ? S_REQ : S_HOLD;
                end else begin
                    kill_s  = kill_r | redirect_valid;
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                pc_s    = redirect_valid ? redir_pc_s : pc_r;
                state_s = (count_s < QFULL) ? S_REQ : S_HOLD;
            end
            default: begin
                state_s = S_BOOT;
                pc_s    = RESET_PC;
                kill_s  = 1'b0;
            end
        endcase
        if ((state_s == S_REQ) && (state_r != S_REQ)) begin
            req_addr_s = pc_s;
        end else begin
            req_addr_s = req_addr_r;
        end
        req_s = (state_s == S_REQ);
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_BOOT;
            pc_r        <= RESET_PC;
            req_addr_r  <= RESET_PC;
            kill_r      <= 1'b0;
            req_r       <= 1'b0;
            count_r     <= 2'd0;
            valid_r     <= 1'b0;
            head_pc_r   <= 32'h0000_0000;
            head_inst_r <= 32'h0000_0000;
            head_pc4_r  <= 32'h0000_0004;
            tail_pc_r   <= 32'h0000_0000;
            tail_inst_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            req_addr_r  <= req_addr_s;
            kill_r      <= kill_s;
            req_r       <= req_s;
            count_r     <= count_s;
            valid_r     <= (count_s != 2'd0);
            head_pc_r   <= head_pc_s;
            head_inst_r <= head_inst_s;
            head_pc4_r  <= head_pc_s + 32'd4;
            tail_pc_r   <= tail_pc_s;
            tail_inst_r <= tail_inst_s;
        end
    end

    assign imem.req  = req_r;
    assign imem.addr = req_addr_r;
    assign if_valid  = valid_r;
    assign if_pc     = head_pc_r;
    assign if_pc4    = head_pc4_r;
    assign if_inst   = head_inst_r;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responders, an in-order instruction-stream reference
// model for ID, directed scenarios, a randomized phase, and a wrap-around RESET_PC instance.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0;
    logic        rst1;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        b_valid;
    logic [31:0] b_pc;
    logic [31:0] b_pc4;
    logic [31:0] b_inst;

    if_fetch_unit_if mb ();
    if_fetch_unit_if bb ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst0), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .imem(mb), .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
        .if_inst(if_inst)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst1), .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .stall(1'b0), .imem(bb), .if_valid(b_valid), .if_pc(b_pc), .if_pc4(b_pc4),
        .if_inst(b_inst)
    );

    int errors = 0;
    int checks = 0;
    int gnt_delay = 0;
    int rv_delay = 0;
    bit rand_mem = 1'b0;
    logic mem_pend;
    logic [31:0] mem_paddr;
    logic [31:0] grant_q[$];
    logic [31:0] exp_pc;
    int pops;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target, input string tag);
        int n = 0;
        while ((grant_q.size() < target) && (n < 100)) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(grant_q.size() >= target), 32'd1);
    endtask

    // Memory for the main instance: programmable grant and data latency.
    initial begin : resp_a
        int g_cnt;
        int rv_cnt;
        int thr;
        int rnd_gd;
        g_cnt = 0; rv_cnt = 0; thr = 0; rnd_gd = 0;
        mem_pend = 1'b0; mem_paddr = 32'h0;
        mb.gnt = 1'b0; mb.rvalid = 1'b0; mb.rdata = 32'h0;
        forever begin
            @(negedge clk);
            mb.gnt = 1'b0;
            mb.rvalid = 1'b0;
            if (rst0) begin
                mem_pend = 1'b0;
                g_cnt = 0;
            end else if (mem_pend) begin
                if (rv_cnt == 0) begin
                    mb.rvalid = 1'b1;
                    mb.rdata = mem_word(mem_paddr);
                    mem_pend = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (mb.req) begin
                thr = rand_mem ? rnd_gd : gnt_delay;
                if (g_cnt >= thr) begin
                    mb.gnt = 1'b1;
                    mem_pend = 1'b1;
                    mem_paddr = mb.addr;
                    grant_q.push_back(mb.addr);
                    rv_cnt = rand_mem ? int'($urandom_range(0, 2)) : rv_delay;
                    rnd_gd = int'($urandom_range(0, 3));
                    g_cnt = 0;
                end else begin
                    g_cnt++;
                end
            end
        end
    end

    // Zero-wait memory for the wrap-around instance.
    initial begin : resp_b
        logic pend_b;
        logic [31:0] addr_b;
        pend_b = 1'b0; addr_b = 32'h0;
        bb.gnt = 1'b0; bb.rvalid = 1'b0; bb.rdata = 32'h0;
        forever begin
            @(negedge clk);
            bb.gnt = 1'b0;
            bb.rvalid = 1'b0;
            if (rst1) begin
                pend_b = 1'b0;
            end else if (pend_b) begin
                bb.rvalid = 1'b1;
                bb.rdata = mem_word(addr_b);
                pend_b = 1'b0;
            end else if (bb.req) begin
                bb.gnt = 1'b1;
                pend_b = 1'b1;
                addr_b = bb.addr;
            end
        end
    end

    // Reference model: ID must see consecutive PCs from the last reset/redirect target.
    initial begin : monitor
        logic hold_p;
        logic [31:0] hold_pc;
        logic wait_p;
        logic [31:0] wait_addr;
        exp_pc = 32'h0; pops = 0;
        hold_p = 1'b0; hold_pc = 32'h0; wait_p = 1'b0; wait_addr = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (wait_p) begin
                chk("req_held", 32'(mb.req), 32'd1);
                chk("addr_stable", mb.addr, wait_addr);
            end
            if (hold_p) begin
                chk("stall_valid", 32'(if_valid), 32'd1);
                chk("stall_pc", if_pc, hold_pc);
            end
            if (rst0) begin
                exp_pc = 32'h0;
                wait_p = 1'b0;
                hold_p = 1'b0;
            end else begin
                if (redirect_valid) begin
                    exp_pc = {redirect_pc[31:2], 2'b00};
                end else if (if_valid && !stall) begin
                    chk("if_pc", if_pc, exp_pc);
                    chk("if_pc4", if_pc4, exp_pc + 32'd4);
                    chk("if_inst", if_inst, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                wait_p = mb.req && !mb.gnt;
                wait_addr = mb.addr;
                hold_p = if_valid && stall && !redirect_valid;
                hold_pc = if_pc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int n0;
        int base;
        rst0 = 1'b1; rst1 = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(2);
        chk("rst_req", 32'(mb.req), 32'd0);
        chk("rst_addr", mb.addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc4", if_pc4, 32'h4);
        grant_q.delete();
        rst0 = 1'b0;

        // 1: sequential fetch, zero-wait memory
        tick(1);
        chk("t1_first_req", 32'(mb.req), 32'd1);
        chk("t1_first_addr", mb.addr, 32'h0);
        tick(12);
        chk("t1_g0", grant_q[0], 32'h0);
        chk("t1_g1", grant_q[1], 32'h4);
        chk("t1_g2", grant_q[2], 32'h8);
        chk("t1_rate", 32'(pops), 32'd5);

        // 2: stall from reset fills the queue, then drains in order
        rst0 = 1'b1; stall = 1'b1;
        tick(1);
        grant_q.delete();
        rst0 = 1'b0;
        tick(8);
        chk("t2_hold_req", 32'(mb.req), 32'd0);
        chk("t2_hold_valid", 32'(if_valid), 32'd1);
        chk("t2_head_pc", if_pc, 32'h0);
        chk("t2_grants", 32'(grant_q.size()), 32'd2);
        stall = 1'b0; rv_delay = 2;
        wait_grants(3, "t2_resume_timeout");
        chk("t2_resume_addr", grant_q[2], 32'h8);

        // 3: redirect while 0x10 is outstanding
        n0 = 0;
        while (!(mem_pend && (mem_paddr == 32'h10)) && (n0 < 60)) begin
            tick(1);
            n0++;
        end
        chk("t3_reach_10", 32'(mem_pend && (mem_paddr == 32'h10)), 32'd1);
        n0 = grant_q.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick(1);
        redirect_valid = 1'b0;
        chk("t3_flush", 32'(if_valid), 32'd0);
        wait_grants(n0 + 1, "t3_next_timeout");
        chk("t3_next_addr", grant_q[n0], 32'h100);
        tick(10);

        // 4: redirect while the request at 0x08 waits for a late grant
        rst0 = 1'b1; rv_delay = 0; gnt_delay = 3;
        tick(1);
        grant_q.delete();
        rst0 = 1'b0;
        n0 = 0;
        while (!(mb.req && (mb.addr == 32'h8)) && (n0 < 60)) begin
            tick(1);
            n0++;
        end
        chk("t4_reach_8", 32'(mb.req && (mb.addr == 32'h8)), 32'd1);
        tick(1);
        chk("t4_not_granted", 32'(grant_q.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick(1);
        redirect_valid = 1'b0;
        chk("t4_addr_hold_a", mb.addr, 32'h8);
        tick(1);
        chk("t4_addr_hold_b", mb.addr, 32'h8);
        chk("t4_req_hold", 32'(mb.req), 32'd1);
        wait_grants(4, "t4_grant_timeout");
        chk("t4_killed_addr", grant_q[2], 32'h8);
        chk("t4_target_addr", grant_q[3], 32'h200);
        tick(12);

        // 5: redirect together with stall while the queue is full
        gnt_delay = 0;
        stall = 1'b1;
        tick(10);
        chk("t5_hold_req", 32'(mb.req), 32'd0);
        chk("t5_hold_valid", 32'(if_valid), 32'd1);
        n0 = grant_q.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        tick(1);
        redirect_valid = 1'b0;
        chk("t5_flush", 32'(if_valid), 32'd0);
        wait_grants(n0 + 1, "t5_grant_timeout");
        chk("t5_target_addr", grant_q[n0], 32'h400);
        tick(3);
        chk("t5_head_valid", 32'(if_valid), 32'd1);
        chk("t5_head_pc", if_pc, 32'h400);
        stall = 1'b0;

        // randomized memory timing, stalls and redirects
        rand_mem = 1'b1;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            tick(1);
        end
        redirect_valid = 1'b0; stall = 1'b0;
        base = pops;
        tick(30);
        chk("rand_live", 32'(pops > base + 5), 32'd1);

        // 6: RESET_PC at the top of the address space, then reset mid-fetch
        rst1 = 1'b0;
        n0 = 0;
        while (!b_valid && (n0 < 20)) begin
            tick(1);
            n0++;
        end
        chk("t6_valid", 32'(b_valid), 32'd1);
        chk("t6_pc", b_pc, 32'hFFFF_FFFC);
        chk("t6_pc4", b_pc4, 32'h0);
        chk("t6_inst", b_inst, mem_word(32'hFFFF_FFFC));
        chk("t6_next_addr", bb.addr, 32'h0);
        chk("t6_next_req", 32'(bb.req), 32'd1);
        tick(1);
        rst1 = 1'b1;
        tick(1);
        chk("t6_rst_valid", 32'(b_valid), 32'd0);
        chk("t6_rst_req", 32'(bb.req), 32'd0);
        chk("t6_rst_addr", bb.addr, 32'hFFFF_FFFC);
        rst1 = 1'b0;
        tick(1);
        chk("t6_refetch_req", 32'(bb.req), 32'd1);
        chk("t6_refetch_addr", bb.addr, 32'hFFFF_FFFC);
        n0 = 0;
        while (!b_valid && (n0 < 20)) begin
            tick(1);
            n0++;
        end
        chk("t6_refetch_pc", b_pc, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
